md_ctrl: RTL
============

// Module: md_ctrl
// PURPOSE
//  Sequencer for the HI/LO multiply/divide resource of the 5-stage MIPS core. Takes
//  mult/multu/div/divu/mthi/mtlo from the E stage, models fixed-latency execution with
//  a busy counter, owns the architectural HI/LO registers and raises the D-stage stall
//  for any HI/LO-using instruction while the unit is occupied.
//  HI/LO outputs feed E-stage mfhi/mflo and are carried down the pipeline registers.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   synchronous, active-high; clears HI, LO, state
//  md_start  in   1   E-stage mult/div issue strobe
//  md_op     in   2   00 mult, 01 multu, 10 div, 11 divu (sampled with md_start)
//  mt_we     in   1   E-stage mthi/mtlo write strobe
//  mt_sel    in   1   0 = write LO, 1 = write HI
//  rs_data   in   32  operand A / mt write data
//  rt_data   in   32  operand B
//  md_use_d  in   1   D-stage instruction is mult/div/mf*/mt*
//  busy      out  1   unit executing
//  done      out  1   one-cycle pulse in last busy cycle
//  md_stall  out  1   stall D stage
//  hi        out  32  architectural HI
//  lo        out  32  architectural LO
// BEHAVIOUR
//  - Reset: state IDLE, cnt=0, hi=lo=0, busy=done=md_stall=0. Reset mid-op aborts; no commit.
//  - States: IDLE, RUN. IDLE & md_start (edge ending cycle t): latch result of op on
//    rs/rt into res_hi/res_lo, cnt <= MULT_CYCLES or DIV_CYCLES, go RUN.
//  - RUN: cnt decrements each edge; busy=1 for cycles t+1..t+N. done=1 when RUN & cnt==1.
//    At that edge hi/lo <= res_hi/res_lo, state IDLE. New HI/LO visible from cycle t+N+1.
//  - mult: signed 32x32->64, {hi,lo} = product. multu: unsigned.
//  - div: lo = quotient truncated toward zero, hi = remainder with dividend sign;
//    0x80000000 / -1 -> lo=0x80000000, hi=0. divu: unsigned.
//  - Divisor 0: full DIV_CYCLES busy, hi/lo left unchanged at commit.
//  - mt_we in IDLE without md_start: selected register <= rs_data next edge, no busy.
//  - md_stall = md_use_d & (md_start | busy); combinational.
//  - md_start while busy: ignored (stall makes this illegal; bench asserts never).
//  - md_start & mt_we in same cycle: md_start wins, mt_we dropped (illegal; assert).
//  - mt_we while busy: ignored (illegal; assert).
//  - Back-to-back: md_start accepted in the cycle after commit (IDLE again).
// STRUCTURE
//  - Shared package md_pkg: md_op encodings (MD_MULT..MD_DIVU), state enum
//    (MD_IDLE, MD_RUN), default latency constants.
//  - One sub-module md_arith: combinational 64-bit result {hi,lo} from op/rs/rt,
//    incl. div-by-zero flag. md_ctrl holds FSM, counter, result latch, HI/LO.
// TESTING
//  - mult rs=0xFFFFFFFD rt=5 -> busy 5 cycles, done in 5th, then hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  - multu rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001 after 5 busy cycles.
//  - div rs=-7 rt=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; div rs=5 rt=0 -> hi/lo unchanged.
//  - md_use_d=1 in issue cycle and every busy cycle -> md_stall=1; drops cycle after done.
//  - mtlo 0x1234 then mthi 0xABCD (no start) -> lo=0x1234, hi=0xABCD next edge, busy=0.
//  - reset asserted in 3rd busy cycle of div -> next cycle busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared encodings and default latencies for the HI/LO
//               multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int c_mult_cycles = 5;
    localparam int c_div_cycles  = 10;

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module      : md_arith
// Description : Combinational 64-bit {hi,lo} result for mult/multu/div/divu,
//               with a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] res,
    output logic        div_zero
);

    logic        w_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_sprod;
    logic [63:0] w_uprod;

    assign w_signed = (op == MD_MULT) || (op == MD_DIV);
    assign w_rs_neg = w_signed & rs[31];
    assign w_rt_neg = w_signed & rt[31];

    // Low 64 bits of a sign-extended product equal the signed 64-bit product.
    assign w_sprod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign w_uprod = {32'b0, rs} * {32'b0, rt};

    // Divide on magnitudes so 0x80000000 / -1 cannot overflow; fix signs after.
    assign w_a_mag  = w_rs_neg ? (~rs + 32'd1) : rs;
    assign w_b_mag  = w_rt_neg ? (~rt + 32'd1) : rt;
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_quo    = w_a_mag / w_b_safe;
    assign w_rem    = w_a_mag % w_b_safe;

    always_comb begin
        res      = 64'd0;
        div_zero = 1'b0;
        case (md_op_e'(op))
            MD_MULT:  res = w_sprod;
            MD_MULTU: res = w_uprod;
            MD_DIV, MD_DIVU: begin
                res[31:0]  = (w_rs_neg ^ w_rt_neg) ? (~w_quo + 32'd1) : w_quo;
                res[63:32] = w_rs_neg ? (~w_rem + 32'd1) : w_rem;
                div_zero   = (rt == 32'd0);
            end
            default: res = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl
// Description : HI/LO multiply/divide sequencer: fixed-latency busy counter,
//               architectural HI/LO registers and D-stage stall generation.
// Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles,
    parameter int DIV_CYCLES  = c_div_cycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_use_d,
    output logic        busy,
    output logic        done,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic               r_res_dz;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [63:0]        w_res;
    logic               w_dz;
    logic               w_latch;
    logic               w_commit;
    logic               w_mt_wr;

    md_arith u_arith (
        .op       (md_op),
        .rs       (rs_data),
        .rt       (rt_data),
        .res      (w_res),
        .div_zero (w_dz)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        w_mt_wr     = 1'b0;
        case (r_state)
            MD_IDLE: begin
                // An issue strobe takes priority over a coincident mthi/mtlo.
                if (md_start) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = md_op[1] ? c_div_cnt : c_mult_cnt;
                    w_state_nxt = MD_RUN;
                end else if (mt_we) begin
                    w_mt_wr = 1'b1;
                end
            end
            MD_RUN: begin
                w_cnt_nxt = r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    w_commit    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = MD_IDLE;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_res_dz <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_res_hi <= w_res[63:32];
                r_res_lo <= w_res[31:0];
                r_res_dz <= w_dz;
            end
            // A zero divisor leaves HI/LO as they were.
            if (w_commit && !r_res_dz) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
            if (w_mt_wr) begin
                if (mt_sel) begin
                    r_hi <= rs_data;
                end else begin
                    r_lo <= rs_data;
                end
            end
        end
    end

    assign busy     = (r_state == MD_RUN);
    assign done     = busy && (r_cnt == c_cnt_one);
    assign md_stall = md_use_d & (md_start | busy);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire
